u_control: RTL

U_CONTROL -- requirements
Module: u_control

---
 rtl/u_control.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/u_control.sv
// Micro-sequencer for a small register/ALU datapath: fetches an instruction over a
// request/ack bus, decodes it and drives register selects and ALU op per cycle.
module u_control #(
  parameter int                                   DATAWIDTH_BUS               = 32,
  parameter int                                   DATAWIDTH_DECODER_SELECTION = 4,
  parameter int                                   DATAWIDTH_ALU_SELECTION     = 4,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0]   ALU_SEL_PASSA               = 4'b0000,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0]   ALU_SEL_INCA                = 4'b0001,
  parameter logic [7:0]                           FETCH_TIMEOUT               = 8'd255
) (
  input  logic                                   uCONTROL_CLOCK_50,
  input  logic                                   uCONTROL_RESET_InLow,
  input  logic                                   uCONTROL_start_InHigh,
  input  logic                                   uCONTROL_step_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               uCONTROL_aluresult_InBUS,
  input  logic                                   uCONTROL_overflow_InLow,
  input  logic                                   uCONTROL_carry_InLow,
  input  logic                                   uCONTROL_negative_InLow,
  input  logic                                   uCONTROL_zero_InLow,
  input  logic                                   uCONTROL_memack_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]               uCONTROL_memdata_InBUS,
  output logic                                   uCONTROL_memreq_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]               uCONTROL_memaddr_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_DECODERA_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_DECODERB_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0] uCONTROL_DECODERC_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uCONTROL_aluselection_OutBUS,
  output logic [3:0]                             uCONTROL_flags_OutBUS,
  output logic                                   uCONTROL_busy_OutHigh,
  output logic                                   uCONTROL_halted_OutHigh,
  output logic                                   uCONTROL_error_OutHigh,
  output logic [15:0]                            uCONTROL_retired_OutBUS
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PCINC  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] REG_PC   = DATAWIDTH_DECODER_SELECTION'(4'd5);
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] REG_NONE = {DATAWIDTH_DECODER_SELECTION{1'b1}};

  state_t                   state_r;
  state_t                   state_s;
  logic [DATAWIDTH_BUS-1:0] ir_r;
  logic [7:0]               wait_cnt_r;
  logic [3:0]               flags_r;
  logic                     error_r;
  logic [15:0]              retired_r;
  logic                     set_error_s;
  logic                     clr_error_s;
  logic                     fetch_timeout_s;
  logic                     ir_unused_s;
  logic [3:0]               cls_s, op_s, rd_s, rs1_s, rs2_s;

  // rd 15 is a legal "discard" target; 7..14 and sources above IR are not.
  function automatic logic alu_legal(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    alu_legal = (rs1 <= 4'd6) && (rs2 <= 4'd6) && !((rd >= 4'd7) && (rd <= 4'd14));
  endfunction

  assign cls_s           = ir_r[31:28];
  assign op_s            = ir_r[27:24];
  assign rd_s            = ir_r[23:20];
  assign rs1_s           = ir_r[19:16];
  assign rs2_s           = ir_r[15:12];
  assign ir_unused_s     = ^ir_r;
  assign fetch_timeout_s = ((wait_cnt_r + 8'd1) == FETCH_TIMEOUT);

  // Next-state logic; an ack in the timeout cycle takes priority.
  always_comb begin
    state_s     = state_r;
    set_error_s = 1'b0;
    clr_error_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (uCONTROL_start_InHigh) state_s = ST_FETCH;
        else                       state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (uCONTROL_memack_InHigh) begin
          state_s = ST_DECODE;
        end else if (fetch_timeout_s) begin
          state_s     = ST_HALT;
          set_error_s = 1'b1;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          4'd0: begin
            if (alu_legal(rd_s, rs1_s, rs2_s)) begin
              state_s = ST_EXEC;
            end else begin
              state_s     = ST_HALT;
              set_error_s = 1'b1;
            end
          end
          4'd1:    state_s = ST_HALT;
          4'd2:    state_s = ST_PCINC;
          default: begin
            state_s     = ST_HALT;
            set_error_s = 1'b1;
          end
        endcase
      end
      ST_EXEC:  state_s = ST_PCINC;
      ST_PCINC: begin
        if (uCONTROL_step_InHigh) state_s = ST_IDLE;
        else                      state_s = ST_FETCH;
      end
      ST_HALT: begin
        if (uCONTROL_start_InHigh) begin
          state_s     = ST_PCINC;
          clr_error_s = 1'b1;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, instruction latch, fetch wait counter, flags, error and retire count.
  always_ff @(posedge uCONTROL_CLOCK_50 or negedge uCONTROL_RESET_InLow) begin
    if (!uCONTROL_RESET_InLow) begin
      state_r    <= ST_IDLE;
      ir_r       <= '0;
      wait_cnt_r <= 8'd0;
      flags_r    <= 4'd0;
      error_r    <= 1'b0;
      retired_r  <= 16'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_FETCH) && uCONTROL_memack_InHigh) begin
        ir_r <= uCONTROL_memdata_InBUS;
      end
      if ((state_r != ST_FETCH) && (state_s == ST_FETCH)) begin
        wait_cnt_r <= 8'd0;
      end else if (state_r == ST_FETCH) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if (state_r == ST_EXEC) begin
        flags_r <= ~{uCONTROL_negative_InLow, uCONTROL_zero_InLow,
                     uCONTROL_overflow_InLow, uCONTROL_carry_InLow};
      end
      if (set_error_s) begin
        error_r <= 1'b1;
      end else if (clr_error_s) begin
        error_r <= 1'b0;
      end
      if (state_r == ST_PCINC) begin
        retired_r <= retired_r + 16'd1;
      end
    end
  end

  // Datapath selects are pure decodes of the state and latched instruction.
  always_comb begin
    uCONTROL_DECODERA_OutBUS     = REG_NONE;
    uCONTROL_DECODERB_OutBUS     = REG_NONE;
    uCONTROL_DECODERC_OutBUS     = REG_NONE;
    uCONTROL_aluselection_OutBUS = ALU_SEL_PASSA;
    case (state_r)
      ST_FETCH: uCONTROL_DECODERA_OutBUS = REG_PC;
      ST_EXEC: begin
        uCONTROL_DECODERA_OutBUS     = DATAWIDTH_DECODER_SELECTION'(rs1_s);
        uCONTROL_DECODERB_OutBUS     = DATAWIDTH_DECODER_SELECTION'(rs2_s);
        uCONTROL_DECODERC_OutBUS     = DATAWIDTH_DECODER_SELECTION'(rd_s);
        uCONTROL_aluselection_OutBUS = DATAWIDTH_ALU_SELECTION'(op_s);
      end
      ST_PCINC: begin
        uCONTROL_DECODERA_OutBUS     = REG_PC;
        uCONTROL_DECODERC_OutBUS     = REG_PC;
        uCONTROL_aluselection_OutBUS = ALU_SEL_INCA;
      end
      default: uCONTROL_DECODERA_OutBUS = REG_NONE;
    endcase
  end

  assign uCONTROL_memaddr_OutBUS = uCONTROL_aluresult_InBUS;
  assign uCONTROL_memreq_OutHigh = (state_r == ST_FETCH);
  assign uCONTROL_busy_OutHigh   = (state_r == ST_FETCH) || (state_r == ST_DECODE) ||
                                   (state_r == ST_EXEC)  || (state_r == ST_PCINC);
  assign uCONTROL_halted_OutHigh = (state_r == ST_HALT);
  assign uCONTROL_error_OutHigh  = error_r;
  assign uCONTROL_flags_OutBUS   = flags_r;
  assign uCONTROL_retired_OutBUS = retired_r;

endmodule
